// File: rtl/mem_arbiter_rr_if.sv
// Bundle of the requester-side and downstream-memory-side signals of the
// L1-to-L2 line arbiter. The arbiter uses the slave view. Requesters and the
// memory model use the master view.
interface mem_arbiter_rr_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    // Requester side
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
    logic [NUM_PORTS-1:0]            req_read;
    logic [NUM_PORTS-1:0]            req_write;
    logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]            req_resp;
    logic [LINE_WIDTH-1:0]           req_rdata;

    // Downstream (L2) side
    logic [ADDR_WIDTH-1:0]           mem_address;
    logic                            mem_read;
    logic                            mem_write;
    logic [LINE_WIDTH-1:0]           mem_wdata;
    logic [LINE_WIDTH-1:0]           mem_rdata;
    logic                            mem_resp;

    modport slave (
        input  req_address, req_read, req_write, req_wdata, mem_rdata, mem_resp,
        output req_resp, req_rdata, mem_address, mem_read, mem_write, mem_wdata
    );

    modport master (
        output req_address, req_read, req_write, req_wdata, mem_rdata, mem_resp,
        input  req_resp, req_rdata, mem_address, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Arbitrates line read/write requests from NUM_PORTS L1 requesters onto a
// single downstream L2 port. Only one downstream transaction is in flight at
// a time. The winner is chosen by fixed priority (POLICY=0) or by round-robin
// (POLICY=1). Its address, data and operation are latched. The memory
// completion is returned to the winner as a one-cycle req_resp pulse.
module mem_arbiter_rr #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int POLICY     = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_rr_if.slave bus
);
    localparam int PTR_WIDTH = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic [NUM_PORTS-1:0]   req_vec;
    logic                   found;
    int                     cand;
    logic [PTR_WIDTH-1:0]   sel;
    logic                   sel_write;

    logic [PTR_WIDTH-1:0]   grant_q;
    logic [PTR_WIDTH-1:0]   rr_ptr_q;
    logic [PTR_WIDTH-1:0]   rr_next;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LINE_WIDTH-1:0]  wdata_q;
    logic [LINE_WIDTH-1:0]  rdata_q;
    logic                   mem_read_q;
    logic                   mem_write_q;
    logic [NUM_PORTS-1:0]   req_resp_q;

    // Pick the winning requester: lowest index, or first at/after rr_ptr with wrap
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        req_vec = bus.req_read | bus.req_write;
        found   = 1'b0;
        cand    = 0;
        sel     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = (POLICY == 0) ? k : ((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (!found && req_vec[cand]) begin
                found = 1'b1;
                sel   = PTR_WIDTH'(cand);
            end
        end
        // Read and write together are serviced as a write.
        sel_write = bus.req_write[sel];
    end

    // Pointer value after the current grant, wrapping at NUM_PORTS-1
    assign rr_next = (grant_q == PTR_WIDTH'(NUM_PORTS - 1)) ? '0
                                                             : grant_q + PTR_WIDTH'(1);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (found)        state_d = BUSY;
            BUSY:    if (bus.mem_resp) state_d = RESPOND;
            RESPOND:                   state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Datapath: latch the winner, drive memory, capture the read line, pulse req_resp
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            req_resp_q  <= '0;
        end else begin
            req_resp_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q     <= sel;
                        addr_q      <= bus.req_address[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q     <= bus.req_wdata[int'(sel)*LINE_WIDTH +: LINE_WIDTH];
                        mem_read_q  <= ~sel_write;
                        mem_write_q <= sel_write;
                    end
                end
                BUSY: begin
                    if (bus.mem_resp) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        // Writes leave the last read line in place.
                        if (mem_read_q) rdata_q <= bus.mem_rdata;
                        req_resp_q  <= NUM_PORTS'(1) << grant_q;
                        rr_ptr_q    <= rr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.req_resp    = req_resp_q;
    assign bus.req_rdata   = rdata_q;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr. It has three instances:
//   u_rr2 : 2 ports, round-robin
//   u_fp2 : 2 ports, fixed priority
//   u_rr3 : 3 ports, round-robin
module tb_mem_arbiter_rr;
    localparam logic [255:0] RLINE = {32{8'hA5}};
    localparam logic [255:0] WLINE = {16{16'h1234}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_rr_if #(.NUM_PORTS(2)) bus_a ();
    mem_arbiter_rr_if #(.NUM_PORTS(2)) bus_b ();
    mem_arbiter_rr_if #(.NUM_PORTS(3)) bus_c ();

    mem_arbiter_rr #(.NUM_PORTS(2), .POLICY(1)) u_rr2 (.clk(clk), .rst(rst), .bus(bus_a));
    mem_arbiter_rr #(.NUM_PORTS(2), .POLICY(0)) u_fp2 (.clk(clk), .rst(rst), .bus(bus_b));
    mem_arbiter_rr #(.NUM_PORTS(3), .POLICY(1)) u_rr3 (.clk(clk), .rst(rst), .bus(bus_c));

    int n_checks = 0;
    int n_pass   = 0;
    int g_a[4];
    int g_b[3];
    int g_c[2];
    int na, nb, nc;
    int exp_rr[4] = '{0, 1, 0, 1};

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh_idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v == (8'd1 << i)) return i;
        return -1;
    endfunction

    task automatic clear_inputs();
        bus_a.req_address = '0; bus_a.req_read = '0; bus_a.req_write = '0;
        bus_a.req_wdata = '0; bus_a.mem_rdata = '0; bus_a.mem_resp = 1'b0;
        bus_b.req_address = '0; bus_b.req_read = '0; bus_b.req_write = '0;
        bus_b.req_wdata = '0; bus_b.mem_rdata = '0; bus_b.mem_resp = 1'b0;
        bus_c.req_address = '0; bus_c.req_read = '0; bus_c.req_write = '0;
        bus_c.req_wdata = '0; bus_c.mem_rdata = '0; bus_c.mem_resp = 1'b0;
    endtask

    task automatic reset_all();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset with requests and mem_resp active: reset must dominate.
        clear_inputs();
        rst = 1'b1;
        bus_a.req_read = 2'b11;
        bus_a.mem_resp = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_mem_read",  {255'd0, bus_a.mem_read},  256'd0);
        check("rst_mem_write", {255'd0, bus_a.mem_write}, 256'd0);
        check("rst_mem_addr",  {224'd0, bus_a.mem_address}, 256'd0);
        check("rst_mem_wdata", bus_a.mem_wdata, 256'd0);
        check("rst_req_resp",  {254'd0, bus_a.req_resp}, 256'd0);
        check("rst_req_rdata", bus_a.req_rdata, 256'd0);
        clear_inputs();

        // Single read from port 1; address changed mid-BUSY; mem_resp at cycle 4.
        bus_a.req_address[63:32] = 32'h0000_1040;
        bus_a.req_read = 2'b10;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("rd_mem_read_c%0d", c), {255'd0, bus_a.mem_read}, 256'd1);
            check($sformatf("rd_mem_write_c%0d", c), {255'd0, bus_a.mem_write}, 256'd0);
            check($sformatf("rd_mem_addr_c%0d", c), {224'd0, bus_a.mem_address}, 256'h1040);
            check($sformatf("rd_no_resp_c%0d", c), {254'd0, bus_a.req_resp}, 256'd0);
            if (c == 2) bus_a.req_address[63:32] = 32'hDEAD_0000;
            if (c == 4) begin
                bus_a.mem_resp  = 1'b1;
                bus_a.mem_rdata = RLINE;
            end
        end
        tick();
        bus_a.mem_resp = 1'b0;
        check("rd_req_resp",   {254'd0, bus_a.req_resp}, 256'd2);
        check("rd_req_rdata",  bus_a.req_rdata, RLINE);
        check("rd_mem_read_5", {255'd0, bus_a.mem_read}, 256'd0);
        bus_a.req_read = 2'b00;
        tick();
        check("rd_resp_one_cycle", {254'd0, bus_a.req_resp}, 256'd0);
        bus_a.mem_resp = 1'b1;  // stray completion while IDLE
        tick();
        bus_a.mem_resp = 1'b0;
        check("idle_resp_ignored", {254'd0, bus_a.req_resp}, 256'd0);
        check("idle_no_mem_read",  {255'd0, bus_a.mem_read}, 256'd0);

        // Write from port 0; request dropped during BUSY still completes.
        bus_a.req_address[31:0] = 32'h0000_2000;
        bus_a.req_wdata[255:0]  = WLINE;
        bus_a.req_write = 2'b01;
        tick();
        check("wr_mem_write", {255'd0, bus_a.mem_write}, 256'd1);
        check("wr_mem_read",  {255'd0, bus_a.mem_read},  256'd0);
        check("wr_mem_addr",  {224'd0, bus_a.mem_address}, 256'h2000);
        check("wr_mem_wdata", bus_a.mem_wdata, WLINE);
        bus_a.req_write = 2'b00;
        tick();
        check("wr_hold_write", {255'd0, bus_a.mem_write}, 256'd1);
        check("wr_hold_wdata", bus_a.mem_wdata, WLINE);
        bus_a.mem_resp = 1'b1;
        tick();
        bus_a.mem_resp = 1'b0;
        check("wr_req_resp",   {254'd0, bus_a.req_resp}, 256'd1);
        check("wr_write_low",  {255'd0, bus_a.mem_write}, 256'd0);
        check("wr_rdata_held", bus_a.req_rdata, RLINE);
        tick();
        check("wr_resp_one_cycle", {254'd0, bus_a.req_resp}, 256'd0);

        // Contention from reset: both ports read continuously on both policies.
        reset_all();
        foreach (g_a[i]) g_a[i] = -1;
        foreach (g_b[i]) g_b[i] = -1;
        na = 0;
        nb = 0;
        bus_a.req_read = 2'b11;
        bus_b.req_read = 2'b11;
        for (int cyc = 0; cyc < 60 && (na < 4 || nb < 3); cyc++) begin
            tick();
            if (bus_a.req_resp != '0 && na < 4) begin
                g_a[na] = oh_idx({6'd0, bus_a.req_resp});
                na++;
            end
            if (bus_b.req_resp != '0 && nb < 3) begin
                g_b[nb] = oh_idx({6'd0, bus_b.req_resp});
                nb++;
            end
            bus_a.mem_resp = bus_a.mem_read | bus_a.mem_write;
            bus_b.mem_resp = bus_b.mem_read | bus_b.mem_write;
        end
        check("rr2_grant_count", 256'(na), 256'd4);
        check("fp2_grant_count", 256'(nb), 256'd3);
        for (int i = 0; i < 4; i++) check($sformatf("rr2_grant%0d", i), 256'(g_a[i]), 256'(exp_rr[i]));
        for (int i = 0; i < 3; i++) check($sformatf("fp2_grant%0d", i), 256'(g_b[i]), 256'd0);
        bus_a.req_read = 2'b00; bus_a.mem_resp = 1'b0;
        bus_b.req_read = 2'b00; bus_b.mem_resp = 1'b0;

        // Three ports: read+write on port 0 is a write and moves rr_ptr to 1.
        bus_c.req_address[31:0] = 32'h0000_3000;
        bus_c.req_read  = 3'b001;
        bus_c.req_write = 3'b001;
        tick();
        check("rr3_both_is_write", {255'd0, bus_c.mem_write}, 256'd1);
        check("rr3_both_not_read", {255'd0, bus_c.mem_read},  256'd0);
        bus_c.mem_resp = 1'b1;
        tick();
        bus_c.mem_resp = 1'b0;
        check("rr3_first_resp", {253'd0, bus_c.req_resp}, 256'd1);
        bus_c.req_write = 3'b000;
        bus_c.req_read  = 3'b101;
        foreach (g_c[i]) g_c[i] = -1;
        nc = 0;
        for (int cyc = 0; cyc < 40 && nc < 2; cyc++) begin
            tick();
            if (bus_c.req_resp != '0) begin
                g_c[nc] = oh_idx({5'd0, bus_c.req_resp});
                nc++;
            end
            bus_c.mem_resp = bus_c.mem_read | bus_c.mem_write;
        end
        check("rr3_grant0", 256'(g_c[0]), 256'd2);
        check("rr3_grant1", 256'(g_c[1]), 256'd0);
        bus_c.req_read = 3'b000;
        bus_c.mem_resp = 1'b0;

        // Reset in BUSY with rr_ptr=1: transaction dropped, next grant from port 0.
        reset_all();
        bus_a.req_read = 2'b01;
        tick();
        bus_a.mem_resp = 1'b1;
        tick();
        bus_a.mem_resp = 1'b0;
        check("rb_first_resp", {254'd0, bus_a.req_resp}, 256'd1);
        tick();
        tick();
        check("rb_busy_c1", {255'd0, bus_a.mem_read}, 256'd1);
        tick();
        check("rb_busy_c2", {255'd0, bus_a.mem_read}, 256'd1);
        rst = 1'b1;
        bus_a.req_read = 2'b00;
        tick();
        rst = 1'b0;
        check("rb_read_low_c3", {255'd0, bus_a.mem_read}, 256'd0);
        tick();
        bus_a.mem_resp = 1'b1;  // late completion of the abandoned read
        tick();
        bus_a.mem_resp = 1'b0;
        check("rb_no_req_resp", {254'd0, bus_a.req_resp}, 256'd0);
        check("rb_read_low_c5", {255'd0, bus_a.mem_read}, 256'd0);
        bus_a.req_read = 2'b11;
        na = 0;
        g_a[0] = -1;
        for (int cyc = 0; cyc < 20 && na < 1; cyc++) begin
            tick();
            if (bus_a.req_resp != '0) begin
                g_a[0] = oh_idx({6'd0, bus_a.req_resp});
                na++;
            end
            bus_a.mem_resp = bus_a.mem_read | bus_a.mem_write;
        end
        check("rb_next_grant_port0", 256'(g_a[0]), 256'd0);
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of L1 requester ports (legal 2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter LINE_WIDTH, default 256, cache-line data width.
REQ-004 SHALL have parameter POLICY, default 1: 0 = fixed priority (port 0 highest), 1 = round-robin.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 req_address  input  NUM_PORTS*ADDR_WIDTH  per-port line address, port i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 req_read  input  NUM_PORTS  per-port line read request.
REQ-010 req_write  input  NUM_PORTS  per-port line write request.
REQ-011 req_wdata  input  NUM_PORTS*LINE_WIDTH  per-port write line, port i at slice [i*LINE_WIDTH +: LINE_WIDTH].
REQ-012 req_resp  output  NUM_PORTS  one-hot completion pulse to the granted port.
REQ-013 req_rdata  output  LINE_WIDTH  read line, shared by all ports, valid only when a req_resp bit is high.
REQ-014 mem_address  output  ADDR_WIDTH  downstream (L2) line address.
REQ-015 mem_read / mem_write  output  1 each  downstream requests, never both high.
REQ-016 mem_wdata  output  LINE_WIDTH  downstream write line.
REQ-017 mem_rdata  input  LINE_WIDTH  downstream read line, valid with mem_resp.
REQ-018 mem_resp  input  1  downstream completion, single-cycle pulse.

Function
REQ-019 SHALL implement FSM with states IDLE, BUSY, RESPOND.
REQ-020 IDLE: port i is requesting when req_read[i]|req_write[i]; if any port requests, SHALL select one per POLICY, latch its address, wdata and op into registers, and enter BUSY next cycle; otherwise stay IDLE.
REQ-021 POLICY=0: lowest-index requesting port SHALL win.
REQ-022 POLICY=1: first requesting port at or after rr_ptr (wrapping NUM_PORTS-1 -> 0) SHALL win; rr_ptr SHALL become (grant+1) mod NUM_PORTS on entering RESPOND.
REQ-023 Port with req_read and req_write both high SHALL be serviced as a write.
REQ-024 BUSY: mem_read or mem_write SHALL be high per latched op, mem_address/mem_wdata SHALL come from latched registers, stable for the whole BUSY period regardless of req_* changes.
REQ-025 BUSY with mem_resp=1: SHALL register mem_rdata, deassert mem_read/mem_write, and enter RESPOND next cycle.
REQ-026 RESPOND: req_resp[grant] SHALL be 1 for exactly one cycle with req_rdata = registered line (write ops: req_rdata holds last registered value, don't-care); then return to IDLE.
REQ-027 Latency: request sampled in IDLE at cycle 0 -> mem_* asserted cycle 1; mem_resp at cycle k -> req_resp at cycle k+1; idle-to-idle minimum 3 cycles.
REQ-028 mem_resp while IDLE or RESPOND SHALL be ignored.
REQ-029 Requesters SHALL hold request until req_resp; a request dropped during BUSY SHALL still complete downstream and pulse req_resp.
REQ-030 At most one downstream transaction SHALL be outstanding; non-granted ports wait with no req_resp.
REQ-031 rr_ptr SHALL be $clog2(NUM_PORTS) bits (min 1) and wrap NUM_PORTS-1 -> 0 for non-power-of-two NUM_PORTS.

Reset
REQ-032 On rst at a clock edge: state=IDLE, rr_ptr=0, grant=0, req_resp=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, req_rdata=0.
REQ-033 rst during BUSY SHALL abandon the transaction (mem_read/mem_write low next cycle, no req_resp); a late mem_resp SHALL be ignored.
REQ-034 rst SHALL dominate all other inputs in the same cycle.

Verification
REQ-035 Single read: port 1 reads 0x0000_1040, mem_resp after 4 cycles with line 0xA5..A5 -> mem_read cycles 1-4 at 0x0000_1040, req_resp=2'b10 cycle 5 with req_rdata 0xA5..A5.
REQ-036 Contention, POLICY=1, NUM_PORTS=2: both ports read continuously from reset -> grants 0,1,0,1; POLICY=0 same stimulus -> grants 0,0,0 while port 0 keeps requesting.
REQ-037 Write: port 0 writes line 0x1234..., address 0x0000_2000 -> mem_write=1, mem_read=0, mem_wdata matches; req_resp=2'b01 one cycle after mem_resp.
REQ-038 NUM_PORTS=3, POLICY=1: ports 0 and 2 request, rr_ptr=1 -> port 2 granted first, then port 0.
REQ-039 Reset mid-BUSY: assert rst at cycle 2 of a read, mem_resp at cycle 4 -> mem_read low from cycle 3, no req_resp, next grant starts from port 0.
REQ-040 Input change during BUSY: granted port changes req_address -> mem_address holds the latched value until mem_resp.
